// File: rtl/wut_sleep_seq.sv
// Wake-up-timer sleep sequencer: isolates and powers down the core, arms the WUT,
// then repowers on expiry. Optional external wake: define WUT_SEQ_EXT_WAKE_EN.
module wut_sleep_seq #(
   parameter int WIDTH        = 9,
   parameter int PWRUP_CYCLES = 16,
   parameter int ARM_TIMEOUT  = 8
) (
   input  logic             perm_clk,
   input  logic             perm_rstb,
   input  logic             sleep_req,
   input  logic [WIDTH-1:0] sleep_limit,
   output logic             sleep_ack,
   input  logic             ext_wake,
   output logic             wake_irq,
   output logic [1:0]       wake_src,
   output logic             perm_pwr_en,
   output logic             perm_iso_en,
   output logic [WIDTH-1:0] perm_wut_limit,
   output logic             perm_wut_disable,
   output logic             perm_wut_start_req,
   input  logic             perm_wut_start_ack,
   input  logic             perm_wut_trig_it
);

   localparam int CMAX = (PWRUP_CYCLES > ARM_TIMEOUT) ? PWRUP_CYCLES : ARM_TIMEOUT;
   localparam int CW   = $clog2(CMAX) + 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISO,
      S_ARM,
      S_SLEEP,
      S_WAKE,
      S_REL
   } state_t;

   state_t           state, state_n;
   logic [CW-1:0]    cnt, cnt_n, cnt_inc;
   logic             rearm, rearm_n;
   logic             ack_q;
   logic             ext_ev;
   logic             expiry;
   logic             pwr_n, iso_n, req_n, dis_n, sack_n, irq_n;
   logic [1:0]       src_n;
   logic [WIDTH-1:0] lim_n;

`ifdef WUT_SEQ_EXT_WAKE_EN
   assign ext_ev = ext_wake;
`else
   logic unused_ext_wake;
   assign unused_ext_wake = ext_wake;
   assign ext_ev = 1'b0;
`endif

   assign cnt_inc = (&cnt) ? cnt : cnt + CW'(1);
   // Timer expiry is either the trigger or the WUT dropping its running ack
   assign expiry  = perm_wut_trig_it | (ack_q & ~perm_wut_start_ack);

   always_comb begin
      state_n = state;
      rearm_n = rearm;
      pwr_n   = perm_pwr_en;
      iso_n   = perm_iso_en;
      req_n   = perm_wut_start_req;
      dis_n   = 1'b0;
      sack_n  = sleep_ack;
      irq_n   = 1'b0;
      src_n   = wake_src;
      lim_n   = perm_wut_limit;
      unique case (state)
         S_IDLE: begin
            if (!sleep_req) begin
               rearm_n = 1'b1;
            end else if (rearm) begin
               rearm_n = 1'b0;
               if (|sleep_limit) begin
                  state_n = S_ISO;
                  lim_n   = sleep_limit;
                  src_n   = 2'b00;
                  iso_n   = 1'b1;
                  sack_n  = 1'b1;
               end else begin
                  state_n = S_REL;
                  src_n   = 2'b11;
               end
            end
         end
         S_ISO: begin
            state_n = S_ARM;
            pwr_n   = 1'b0;
            req_n   = 1'b1;
         end
         S_ARM: begin
            if (perm_wut_start_ack) begin
               state_n = S_SLEEP;
               req_n   = 1'b0;
            end else if (ext_ev || cnt == CW'(ARM_TIMEOUT - 1)) begin
               state_n = S_WAKE;
               req_n   = 1'b0;
               dis_n   = 1'b1;
               pwr_n   = 1'b1;
               src_n   = ext_ev ? 2'b10 : 2'b11;
            end
         end
         S_SLEEP: begin
            if (expiry) begin
               state_n = S_WAKE;
               pwr_n   = 1'b1;
               src_n   = 2'b01;
            end else if (ext_ev) begin
               state_n = S_WAKE;
               pwr_n   = 1'b1;
               dis_n   = 1'b1;
               src_n   = 2'b10;
            end
         end
         S_WAKE: begin
            if (cnt == CW'(PWRUP_CYCLES - 1)) begin
               state_n = S_REL;
               sack_n  = 1'b0;
            end
         end
         S_REL: begin
            state_n = S_IDLE;
            iso_n   = 1'b0;
            irq_n   = 1'b1;
         end
         default: state_n = S_IDLE;
      endcase
      cnt_n = (state_n != state) ? '0 : cnt_inc;
   end

   always_ff @(posedge perm_clk) begin
      if (!perm_rstb) begin
         state              <= S_IDLE;
         cnt                <= '0;
         rearm              <= 1'b1;
         ack_q              <= 1'b0;
         perm_pwr_en        <= 1'b1;
         perm_iso_en        <= 1'b0;
         perm_wut_start_req <= 1'b0;
         perm_wut_disable   <= 1'b0;
         perm_wut_limit     <= '0;
         sleep_ack          <= 1'b0;
         wake_irq           <= 1'b0;
         wake_src           <= 2'b00;
      end else begin
         state              <= state_n;
         cnt                <= cnt_n;
         rearm              <= rearm_n;
         ack_q              <= perm_wut_start_ack;
         perm_pwr_en        <= pwr_n;
         perm_iso_en        <= iso_n;
         perm_wut_start_req <= req_n;
         perm_wut_disable   <= dis_n;
         perm_wut_limit     <= lim_n;
         sleep_ack          <= sack_n;
         wake_irq           <= irq_n;
         wake_src           <= src_n;
      end
   end

endmodule

// File: tb/tb_wut_sleep_seq.sv
// Directed bench for wut_sleep_seq: table-driven timer path plus
// hand-written timeout, zero-limit, external-wake and reset sequences.
module tb_wut_sleep_seq;

   localparam int W  = 9;
   localparam int PU = 16;
   localparam int AT = 8;

   logic         perm_clk = 1'b0;
   logic         perm_rstb;
   logic         sleep_req;
   logic [W-1:0] sleep_limit;
   logic         sleep_ack;
   logic         ext_wake;
   logic         wake_irq;
   logic [1:0]   wake_src;
   logic         perm_pwr_en;
   logic         perm_iso_en;
   logic [W-1:0] perm_wut_limit;
   logic         perm_wut_disable;
   logic         perm_wut_start_req;
   logic         perm_wut_start_ack;
   logic         perm_wut_trig_it;

   int checks = 0;
   int errors = 0;

   wut_sleep_seq #(
      .WIDTH(W), .PWRUP_CYCLES(PU), .ARM_TIMEOUT(AT)
   ) dut (
      .perm_clk(perm_clk),
      .perm_rstb(perm_rstb),
      .sleep_req(sleep_req),
      .sleep_limit(sleep_limit),
      .sleep_ack(sleep_ack),
      .ext_wake(ext_wake),
      .wake_irq(wake_irq),
      .wake_src(wake_src),
      .perm_pwr_en(perm_pwr_en),
      .perm_iso_en(perm_iso_en),
      .perm_wut_limit(perm_wut_limit),
      .perm_wut_disable(perm_wut_disable),
      .perm_wut_start_req(perm_wut_start_req),
      .perm_wut_start_ack(perm_wut_start_ack),
      .perm_wut_trig_it(perm_wut_trig_it)
   );

   always #5 perm_clk = ~perm_clk;

   typedef struct {
      logic         req;
      logic [W-1:0] lim;
      logic         ack;
      logic         trig;
      logic         e_ack;
      logic         e_pwr;
      logic         e_iso;
      logic         e_req;
      logic         e_dis;
      logic         e_irq;
      logic [1:0]   e_src;
      logic [W-1:0] e_wl;
   } vec_t;

   vec_t tv [10];

   task automatic step();
      @(posedge perm_clk);
      #1;
   endtask

   task automatic cmp(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got=%0h want=%0h", nm, act, exp);
      end
   endtask

   task automatic expect_o(input string nm, input logic ak, input logic pw,
                           input logic is, input logic rq, input logic ds,
                           input logic ir, input logic [1:0] src,
                           input logic [W-1:0] wl);
      cmp({nm, ".sleep_ack"}, 32'(sleep_ack), 32'(ak));
      cmp({nm, ".pwr_en"}, 32'(perm_pwr_en), 32'(pw));
      cmp({nm, ".iso_en"}, 32'(perm_iso_en), 32'(is));
      cmp({nm, ".start_req"}, 32'(perm_wut_start_req), 32'(rq));
      cmp({nm, ".disable"}, 32'(perm_wut_disable), 32'(ds));
      cmp({nm, ".wake_irq"}, 32'(wake_irq), 32'(ir));
      cmp({nm, ".wake_src"}, 32'(wake_src), 32'(src));
      cmp({nm, ".wut_limit"}, 32'(perm_wut_limit), 32'(wl));
   endtask

   // Called on the first WAKE cycle; walks power-up, release and the irq pulse
   task automatic wake_seq(input string nm, input logic [1:0] src,
                           input logic [W-1:0] wl);
      for (int i = 1; i < PU; i++) begin
         step();
         expect_o({nm, ".wake"}, 1, 1, 1, 0, 0, 0, src, wl);
      end
      step();
      expect_o({nm, ".release"}, 0, 1, 1, 0, 0, 0, src, wl);
      step();
      expect_o({nm, ".irq"}, 0, 1, 0, 0, 0, 1, src, wl);
      step();
      expect_o({nm, ".idle"}, 0, 1, 0, 0, 0, 0, src, wl);
   endtask

   task automatic enter_sleep(input string nm, input logic [W-1:0] lim,
                              input logic [1:0] old_src);
      sleep_req = 1'b0;
      step();
      sleep_req   = 1'b1;
      sleep_limit = lim;
      step();
      expect_o({nm, ".iso"}, 1, 1, 1, 0, 0, 0, 2'b00, lim);
      step();
      expect_o({nm, ".arm"}, 1, 0, 1, 1, 0, 0, 2'b00, lim);
      perm_wut_start_ack = 1'b1;
      step();
      expect_o({nm, ".sleep"}, 1, 0, 1, 0, 0, 0, 2'b00, lim);
      if (old_src == 2'b11) $display("note: entering sleep after error wake");
   endtask

   initial begin
      //        req lim   ack trig  ack pwr iso rq dis irq src    wl
      tv[0] = '{0, 9'd5, 0, 0,     0, 1, 0, 0, 0, 0, 2'b00, 9'd0};
      tv[1] = '{1, 9'd5, 0, 0,     1, 1, 1, 0, 0, 0, 2'b00, 9'd5};
      tv[2] = '{1, 9'd3, 0, 0,     1, 0, 1, 1, 0, 0, 2'b00, 9'd5};
      tv[3] = '{1, 9'd3, 0, 0,     1, 0, 1, 1, 0, 0, 2'b00, 9'd5};
      tv[4] = '{1, 9'd3, 1, 0,     1, 0, 1, 0, 0, 0, 2'b00, 9'd5};
      tv[5] = '{1, 9'd3, 1, 0,     1, 0, 1, 0, 0, 0, 2'b00, 9'd5};
      tv[6] = '{1, 9'd3, 1, 0,     1, 0, 1, 0, 0, 0, 2'b00, 9'd5};
      tv[7] = '{1, 9'd3, 1, 0,     1, 0, 1, 0, 0, 0, 2'b00, 9'd5};
      tv[8] = '{1, 9'd3, 1, 0,     1, 0, 1, 0, 0, 0, 2'b00, 9'd5};
      tv[9] = '{1, 9'd3, 0, 0,     1, 1, 1, 0, 0, 0, 2'b01, 9'd5};

      perm_rstb          = 1'b0;
      sleep_req          = 1'b1;
      sleep_limit        = 9'd5;
      ext_wake           = 1'b0;
      perm_wut_start_ack = 1'b0;
      perm_wut_trig_it   = 1'b0;

      // Reset held with a pending request: stays idle
      for (int i = 0; i < 3; i++) begin
         step();
         expect_o("reset", 0, 1, 0, 0, 0, 0, 2'b00, 9'd0);
      end
      sleep_req = 1'b0;
      perm_rstb = 1'b1;

      // Timer path: ack after 2 ARM cycles, ack drops after 5 more
      for (int i = 0; i < 10; i++) begin
         sleep_req          = tv[i].req;
         sleep_limit        = tv[i].lim;
         perm_wut_start_ack = tv[i].ack;
         perm_wut_trig_it   = tv[i].trig;
         step();
         expect_o($sformatf("vec%0d", i), tv[i].e_ack, tv[i].e_pwr,
                  tv[i].e_iso, tv[i].e_req, tv[i].e_dis, tv[i].e_irq,
                  tv[i].e_src, tv[i].e_wl);
      end
      wake_seq("timer", 2'b01, 9'd5);

      // Request still high: no re-sleep until it drops
      sleep_limit = 9'd5;
      for (int i = 0; i < 2; i++) begin
         step();
         expect_o("norearm", 0, 1, 0, 0, 0, 0, 2'b01, 9'd5);
      end

      // ARM timeout with ack tied low
      sleep_req = 1'b0;
      step();
      sleep_req   = 1'b1;
      sleep_limit = 9'd7;
      step();
      expect_o("to.iso", 1, 1, 1, 0, 0, 0, 2'b00, 9'd7);
      step();
      expect_o("to.arm0", 1, 0, 1, 1, 0, 0, 2'b00, 9'd7);
      for (int i = 1; i < AT; i++) begin
         step();
         expect_o("to.arm", 1, 0, 1, 1, 0, 0, 2'b00, 9'd7);
      end
      step();
      expect_o("to.dis", 1, 1, 1, 0, 1, 0, 2'b11, 9'd7);
      wake_seq("to", 2'b11, 9'd7);

      // Zero limit: straight to release, core untouched
      sleep_req = 1'b0;
      step();
      sleep_req   = 1'b1;
      sleep_limit = 9'd0;
      step();
      expect_o("zero.rel", 0, 1, 0, 0, 0, 0, 2'b11, 9'd7);
      step();
      expect_o("zero.irq", 0, 1, 0, 0, 0, 1, 2'b11, 9'd7);
      step();
      expect_o("zero.idle", 0, 1, 0, 0, 0, 0, 2'b11, 9'd7);

`ifdef WUT_SEQ_EXT_WAKE_EN
      enter_sleep("ext", 9'd4, 2'b00);
      for (int i = 0; i < 2; i++) begin
         step();
         expect_o("ext.sleep", 1, 0, 1, 0, 0, 0, 2'b00, 9'd4);
      end
      ext_wake = 1'b1;
      step();
      ext_wake = 1'b0;
      expect_o("ext.wake", 1, 1, 1, 0, 1, 0, 2'b10, 9'd4);
      wake_seq("ext", 2'b10, 9'd4);

      enter_sleep("both", 9'd6, 2'b10);
      ext_wake         = 1'b1;
      perm_wut_trig_it = 1'b1;
      step();
      ext_wake           = 1'b0;
      perm_wut_trig_it   = 1'b0;
      perm_wut_start_ack = 1'b0;
      expect_o("both.wake", 1, 1, 1, 0, 0, 0, 2'b01, 9'd6);
      wake_seq("both", 2'b01, 9'd6);
`else
      // ext_wake has no effect in this build
      enter_sleep("noext", 9'd4, 2'b11);
      ext_wake = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         expect_o("noext.sleep", 1, 0, 1, 0, 0, 0, 2'b00, 9'd4);
      end
      ext_wake         = 1'b0;
      perm_wut_trig_it = 1'b1;
      step();
      perm_wut_trig_it   = 1'b0;
      perm_wut_start_ack = 1'b0;
      expect_o("trig.wake", 1, 1, 1, 0, 0, 0, 2'b01, 9'd4);
      wake_seq("trig", 2'b01, 9'd4);
`endif

      // Reset during WAKE
      enter_sleep("rst", 9'd5, 2'b01);
      perm_wut_start_ack = 1'b0;
      step();
      expect_o("rst.wake", 1, 1, 1, 0, 0, 0, 2'b01, 9'd5);
      step();
      step();
      perm_rstb = 1'b0;
      step();
      expect_o("rst.hit", 0, 1, 0, 0, 0, 0, 2'b00, 9'd0);
      perm_rstb = 1'b1;
      sleep_req = 1'b0;
      step();
      expect_o("rst.idle", 0, 1, 0, 0, 0, 0, 2'b00, 9'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
